// File: rtl/imm_gen.sv
// Purpose: decode-stage RISC-V immediate generator; sign-extends the immediate field chosen by InstFormat.
// Latency: 1 cycle from an accepted input (in_valid high at a rising edge) to Imm/out_valid.
// Backpressure: none; accepts one instruction per cycle, and bubbles hold Imm while out_valid drops.

package imm_gen_pkg;
    localparam logic [2:0] InstFormat_R  = 3'd0;
    localparam logic [2:0] InstFormat_I  = 3'd1;
    localparam logic [2:0] InstFormat_S  = 3'd2;
    localparam logic [2:0] InstFormat_SB = 3'd3;
    localparam logic [2:0] InstFormat_U  = 3'd4;
    localparam logic [2:0] InstFormat_UJ = 3'd5;
endpackage

module imm_gen
    import imm_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  InstFormat,
    input  logic [31:0] Inst,
    input  logic        in_valid,
    output logic [31:0] Imm,
    output logic        out_valid,
    output logic        fmt_err
);

    logic [31:0] imm_d;
    logic [31:0] imm_q;
    logic        illegal_d;
    logic        out_valid_q;
    logic        fmt_err_q;
    logic        s;

    // Inst[31] is the sign bit for every format.
    assign s = Inst[31];

    // Extract and sign-extend the immediate; the opcode bits play no part in format selection.
    always_comb begin
        imm_d     = 32'h0;
        illegal_d = 1'b0;
        case (InstFormat)
            InstFormat_R:  imm_d = 32'h0;
            InstFormat_I:  imm_d = {{20{s}}, Inst[31:20]};
            InstFormat_S:  imm_d = {{20{s}}, Inst[31:25], Inst[11:7]};
            InstFormat_SB: imm_d = {{19{s}}, Inst[31], Inst[7], Inst[30:25], Inst[11:8], 1'b0};
            InstFormat_U:  imm_d = {Inst[31:12], 12'b0};
            InstFormat_UJ: imm_d = {{11{s}}, Inst[31], Inst[19:12], Inst[20], Inst[30:21], 1'b0};
            default: begin
                imm_d     = 32'h0;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Output registers: capture on in_valid, hold Imm across bubbles, and clear the valid and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q       <= 32'h0;
            out_valid_q <= 1'b0;
            fmt_err_q   <= 1'b0;
        end else if (in_valid) begin
            imm_q       <= imm_d;
            out_valid_q <= 1'b1;
            fmt_err_q   <= illegal_d;
        end else begin
            out_valid_q <= 1'b0;
            fmt_err_q   <= 1'b0;
        end
    end

    assign Imm       = imm_q;
    assign out_valid = out_valid_q;
    assign fmt_err   = fmt_err_q;

endmodule

// File: tb/tb_imm_gen.sv
// Purpose: directed self-checking bench for imm_gen covering every format, sign extension, valid gating and async reset.
// Latency: expects results 1 cycle after each accepted vector, sampled 1 time unit after the rising edge.
// Backpressure: not applicable; stimulus is driven on falling edges.

module tb_imm_gen;

    logic        clk;
    logic        rst_n;
    logic [2:0]  InstFormat;
    logic [31:0] Inst;
    logic        in_valid;
    logic [31:0] Imm;
    logic        out_valid;
    logic        fmt_err;

    int vec_cnt;
    int err_cnt;

    imm_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .InstFormat (InstFormat),
        .Inst       (Inst),
        .in_valid   (in_valid),
        .Imm        (Imm),
        .out_valid  (out_valid),
        .fmt_err    (fmt_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one vector on the falling edge and then sample just after the next rising edge.
    task automatic apply(input logic [2:0] fmt, input logic [31:0] inst, input logic vld);
        @(negedge clk);
        InstFormat = fmt;
        Inst       = inst;
        in_valid   = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n      = 1'b1;
        in_valid   = 1'b1;
        InstFormat = 3'd1;
        Inst       = $urandom;
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (Imm !== 32'h0 || out_valid !== 1'b0 || fmt_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_assert: Imm=%h out_valid=%b fmt_err=%b, required 0/0/0", Imm, out_valid, fmt_err);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            Inst       = $urandom;
            InstFormat = 3'($urandom_range(1, 5));
            @(posedge clk);
            #1;
            vec_cnt++;
            if (Imm !== 32'h0 || out_valid !== 1'b0 || fmt_err !== 1'b0) begin
                err_cnt++;
                $display("FAIL reset_hold[%0d]: Imm=%h out_valid=%b fmt_err=%b, required 0/0/0", i, Imm, out_valid, fmt_err);
            end
        end
        // Release on a falling edge; the very next rising edge must capture.
        @(negedge clk);
        rst_n      = 1'b1;
        InstFormat = 3'd1;
        Inst       = 32'h00108093;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        vec_cnt++;
        if (Imm !== 32'h00000001 || out_valid !== 1'b1 || fmt_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_first_capture: Imm=%h out_valid=%b fmt_err=%b, required 00000001/1/0", Imm, out_valid, fmt_err);
        end
    endtask

    task automatic test_formats;
        logic [2:0]  fmts [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        logic [31:0] insts[5] = '{32'h00108093, 32'h001080A3, 32'h0010830F, 32'h000010B7, 32'h0010836F};
        logic [31:0] exps [5] = '{32'h00000001, 32'h00000001, 32'h00000006, 32'h00001000, 32'h00008800};
        for (int i = 0; i < 5; i++) begin
            apply(fmts[i], insts[i], 1'b1);
            vec_cnt++;
            if (Imm !== exps[i] || out_valid !== 1'b1 || fmt_err !== 1'b0) begin
                err_cnt++;
                $display("FAIL format[%0d] fmt=%0d: Imm=%h out_valid=%b fmt_err=%b, required %h/1/0",
                         i, fmts[i], Imm, out_valid, fmt_err, exps[i]);
            end
        end
    endtask

    task automatic test_sign_ext;
        logic [2:0]  fmts[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        logic [31:0] exps[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFF000, 32'hFFFFFFFE};
        for (int i = 0; i < 5; i++) begin
            apply(fmts[i], 32'hFFFFFFFF, 1'b1);
            vec_cnt++;
            if (Imm !== exps[i] || out_valid !== 1'b1) begin
                err_cnt++;
                $display("FAIL sign_ext fmt=%0d: Imm=%h out_valid=%b, required %h/1", fmts[i], Imm, out_valid, exps[i]);
            end
        end
    endtask

    task automatic test_r_and_illegal;
        apply(3'd0, 32'hFFFFFFFF, 1'b1);
        vec_cnt++;
        if (Imm !== 32'h0 || fmt_err !== 1'b0 || out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL r_format: Imm=%h fmt_err=%b out_valid=%b, required 0/0/1", Imm, fmt_err, out_valid);
        end
        apply(3'd6, 32'hFFFFFFFF, 1'b1);
        vec_cnt++;
        if (Imm !== 32'h0 || fmt_err !== 1'b1 || out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL illegal6: Imm=%h fmt_err=%b out_valid=%b, required 0/1/1", Imm, fmt_err, out_valid);
        end
        // Following bubble must drop fmt_err after one cycle.
        apply(3'd6, 32'hFFFFFFFF, 1'b0);
        vec_cnt++;
        if (fmt_err !== 1'b0 || out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL illegal6_one_cycle: fmt_err=%b out_valid=%b, required 0/0", fmt_err, out_valid);
        end
        apply(3'd7, 32'h12345678, 1'b1);
        vec_cnt++;
        if (Imm !== 32'h0 || fmt_err !== 1'b1) begin
            err_cnt++;
            $display("FAIL illegal7: Imm=%h fmt_err=%b, required 0/1", Imm, fmt_err);
        end
        // A legal vector right after must clear fmt_err.
        apply(3'd1, 32'h00300093, 1'b1);
        vec_cnt++;
        if (Imm !== 32'h00000003 || fmt_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL illegal_then_legal: Imm=%h fmt_err=%b, required 00000003/0", Imm, fmt_err);
        end
    endtask

    task automatic test_valid_gating;
        apply(3'd1, 32'h00500093, 1'b1);
        vec_cnt++;
        if (Imm !== 32'h5 || out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL gating_first: Imm=%h out_valid=%b, required 00000005/1", Imm, out_valid);
        end
        apply(3'd1, 32'h00900093, 1'b0);
        vec_cnt++;
        if (Imm !== 32'h5 || out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL gating_hold: Imm=%h out_valid=%b, required 00000005/0", Imm, out_valid);
        end
        apply(3'd1, 32'h00700093, 1'b1);
        vec_cnt++;
        if (Imm !== 32'h7 || out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL gating_third: Imm=%h out_valid=%b, required 00000007/1", Imm, out_valid);
        end
        // Input changes between edges must not reach the outputs.
        Inst       = 32'hFFF00093;
        InstFormat = 3'd1;
        #2;
        vec_cnt++;
        if (Imm !== 32'h7 || out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_cycle_change: Imm=%h out_valid=%b, required 00000007/1", Imm, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exps[4] = '{32'h00000010, 32'h00000020, 32'hFFFFF800, 32'h00000030};
        logic [31:0] insts[4] = '{32'h01000093, 32'h02000093, 32'h80000093, 32'h03000093};
        for (int i = 0; i < 4; i++) begin
            apply(3'd1, insts[i], 1'b1);
            vec_cnt++;
            if (Imm !== exps[i] || out_valid !== 1'b1) begin
                err_cnt++;
                $display("FAIL back_to_back[%0d]: Imm=%h out_valid=%b, required %h/1", i, Imm, out_valid, exps[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        apply(3'd4, 32'hABCDE0B7, 1'b1);
        vec_cnt++;
        if (Imm !== 32'hABCDE000 || out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL async_pre: Imm=%h out_valid=%b, required abcde000/1", Imm, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (Imm !== 32'h0 || out_valid !== 1'b0 || fmt_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_clear: Imm=%h out_valid=%b fmt_err=%b, required 0/0/0", Imm, out_valid, fmt_err);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        vec_cnt++;
        if (Imm !== 32'h0 || out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_no_partial: Imm=%h out_valid=%b, required 0/0", Imm, out_valid);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_formats();
        test_sign_ext();
        test_r_and_illegal();
        test_valid_gating();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
